// File: rtl/fp_result_monitor.sv
// fp_result_monitor: FIFO capture of FP add/sub samples; FP_MON_CLASS_EN adds result classification and NaN counting
module fp_result_monitor #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic                     in_op,
  input  logic [WIDTH-1:0]         in_result,
  output logic                     in_ready,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_a,
  output logic [WIDTH-1:0]         out_b,
  output logic [WIDTH-1:0]         out_result,
  output logic                     out_op,
  output logic [2:0]               out_class,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [15:0]              drop_cnt,
  output logic [15:0]              nan_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, ACTIVE, FULL} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0] drop_q, drop_d;
  logic push, pop;
  logic [WIDTH-1:0] a_mem [DEPTH];
  logic [WIDTH-1:0] b_mem [DEPTH];
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic op_mem [DEPTH];
  assign full = state_q == FULL;
  assign empty = state_q == IDLE;
  assign in_ready = !full;
  assign out_valid = !empty;
  assign count = count_q;
  assign drop_cnt = drop_q;
  assign out_a = out_valid ? a_mem[rd_q] : '0;
  assign out_b = out_valid ? b_mem[rd_q] : '0;
  assign out_result = out_valid ? r_mem[rd_q] : '0;
  assign out_op = out_valid ? op_mem[rd_q] : 1'b0;
  always_comb begin
    push = in_valid && in_ready && !flush;
    pop = out_valid && out_ready && !flush;
    wr_d = flush ? '0 : push ? wr_q + AW'(1) : wr_q;
    rd_d = flush ? '0 : pop ? rd_q + AW'(1) : rd_q;
    count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
    drop_d = (in_valid && !in_ready && !flush && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    state_d = count_d == '0 ? IDLE : count_d == CW'(DEPTH) ? FULL : ACTIVE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
      drop_q <= drop_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      a_mem[wr_q] <= in_a;
      b_mem[wr_q] <= in_b;
      r_mem[wr_q] <= in_result;
      op_mem[wr_q] <= in_op;
    end
  end
`ifdef FP_MON_CLASS_EN
  logic [2:0] cls_in;
  logic [2:0] c_mem [DEPTH];
  logic [15:0] nan_q, nan_d;
  assign out_class = out_valid ? c_mem[rd_q] : '0;
  assign nan_cnt = nan_q;
  always_comb begin
    cls_in = in_result[30:23] == 8'h00 ? (in_result[22:0] == '0 ? 3'd0 : 3'd1) :
             in_result[30:23] == 8'hFF ? (in_result[22:0] == '0 ? 3'd3 : 3'd4) : 3'd2;
    nan_d = (push && cls_in == 3'd4 && nan_q != 16'hFFFF) ? nan_q + 16'd1 : nan_q;
  end
  always_ff @(posedge clk) begin
    if (rst) nan_q <= '0;
    else nan_q <= nan_d;
  end
  always_ff @(posedge clk) begin
    if (push) c_mem[wr_q] <= cls_in;
  end
`else
  assign out_class = '0;
  assign nan_cnt = '0;
`endif
endmodule

// File: tb/tb_fp_result_monitor.sv
// tb_fp_result_monitor: table-driven and scoreboard checks of the FP result capture FIFO
module tb_fp_result_monitor;
  localparam int DEPTH = 8;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] r;
    logic [2:0]  cls;
  } entry_t;
  typedef struct {
    logic [31:0] r;
    logic [2:0]  cls;
  } cls_vec_t;
  logic clk = 0, rst, in_valid, in_op, in_ready, flush, out_valid, out_ready, out_op, full, empty;
  logic [31:0] in_a, in_b, in_result, out_a, out_b, out_result;
  logic [2:0] out_class;
  logic [3:0] count;
  logic [15:0] drop_cnt, nan_cnt;
  int checks = 0, errors = 0;
  int m_count = 0;
  logic [15:0] m_drop = 0, m_nan = 0;
  entry_t exp_q[$];
  cls_vec_t cv[6];
  fp_result_monitor #(.WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .in_result(in_result), .in_ready(in_ready), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_a(out_a), .out_b(out_b), .out_result(out_result),
    .out_op(out_op), .out_class(out_class), .count(count), .full(full), .empty(empty),
    .drop_cnt(drop_cnt), .nan_cnt(nan_cnt)
  );
  always #5 clk = ~clk;
  function automatic logic [2:0] exp_class(input logic [31:0] v);
`ifdef FP_MON_CLASS_EN
    logic [7:0] e;
    e = v[30:23];
    if (e == 8'h00) return (v[22:0] == 0) ? 3'd0 : 3'd1;
    if (e == 8'hFF) return (v[22:0] == 0) ? 3'd3 : 3'd4;
    return 3'd2;
`else
    return (v == 32'hDEAD_BEEF) ? 3'd7 & 3'd0 : 3'd0;
`endif
  endfunction
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic check_state(input string tag);
    check({tag, "/count"}, 64'(count), 64'(m_count));
    check({tag, "/full"}, 64'(full), 64'(m_count == DEPTH));
    check({tag, "/empty"}, 64'(empty), 64'(m_count == 0));
    check({tag, "/in_ready"}, 64'(in_ready), 64'(m_count != DEPTH));
    check({tag, "/drop_cnt"}, 64'(drop_cnt), 64'(m_drop));
    check({tag, "/nan_cnt"}, 64'(nan_cnt), 64'(m_nan));
    check({tag, "/out_valid"}, 64'(out_valid), 64'(m_count != 0));
    if (m_count != 0) begin
      check({tag, "/out_a"}, 64'(out_a), 64'(exp_q[0].a));
      check({tag, "/out_b"}, 64'(out_b), 64'(exp_q[0].b));
      check({tag, "/out_op"}, 64'(out_op), 64'(exp_q[0].op));
      check({tag, "/out_result"}, 64'(out_result), 64'(exp_q[0].r));
      check({tag, "/out_class"}, 64'(out_class), 64'(exp_q[0].cls));
    end else begin
      check({tag, "/idle_fields"}, {out_a, out_b}, 64'd0);
      check({tag, "/idle_res"}, {out_result, 28'd0, out_op, out_class}, 64'd0);
    end
  endtask
  task automatic cycle(input logic r, input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic op, input logic [31:0] res, input logic ordy, input logic fl,
                       input string tag);
    logic acc, pp;
    entry_t e;
    rst = r; in_valid = v; in_a = a; in_b = b; in_op = op; in_result = res;
    out_ready = ordy; flush = fl;
    acc = !r && !fl && v && m_count < DEPTH;
    pp = !r && !fl && ordy && m_count > 0;
    @(posedge clk);
    #1;
    if (r) begin
      m_count = 0; m_drop = 0; m_nan = 0; exp_q.delete();
    end else if (fl) begin
      m_count = 0; exp_q.delete();
    end else begin
      if (v && !acc && m_drop != 16'hFFFF) m_drop++;
      if (pp) begin
        void'(exp_q.pop_front());
        m_count--;
      end
      if (acc) begin
        e.a = a; e.b = b; e.op = op; e.r = res; e.cls = exp_class(res);
        exp_q.push_back(e);
        m_count++;
        if (e.cls == 3'd4 && m_nan != 16'hFFFF) m_nan++;
      end
    end
    check_state(tag);
  endtask
  task automatic push_n(input int n, input int base, input logic ordy, input string tag);
    for (int i = 0; i < n; i++)
      cycle(0, 1, 32'h3F80_0000 + base + i, 32'h4000_0000 + base + i, 1'((base + i) % 2),
            32'h4040_0000 + base + i, ordy, 0, tag);
  endtask
  task automatic drain(input string tag);
    for (int i = 0; i < DEPTH + 1; i++) cycle(0, 0, 0, 0, 0, 0, 1, 0, tag);
    check({tag, "/drained"}, 64'(empty), 64'd1);
  endtask
  initial begin
    cv[0] = '{32'h0000_0000, 3'd0};
    cv[1] = '{32'h0000_0001, 3'd1};
    cv[2] = '{32'h7F80_0000, 3'd3};
    cv[3] = '{32'h7FC0_0000, 3'd4};
    cv[4] = '{32'hFF80_0000, 3'd3};
    cv[5] = '{32'hBF80_0000, 3'd2};
    cycle(1, 0, 0, 0, 0, 0, 0, 0, "reset");
    cycle(1, 1, 32'h1, 32'h2, 1, 32'h3, 1, 1, "reset2");
    cycle(0, 1, 32'h3F80_0000, 32'h4000_0000, 0, 32'h4040_0000, 0, 0, "first");
    check("first/result", 64'(out_result), 64'h4040_0000);
    check("first/class", 64'(out_class), `ifdef FP_MON_CLASS_EN 64'd2 `else 64'd0 `endif);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, "hold");
    drain("first_drain");
    push_n(DEPTH, 16, 0, "fill");
    check("fill/full", 64'(full), 64'd1);
    push_n(2, 32, 0, "overflow");
    check("overflow/drop", 64'(drop_cnt), 64'd2);
    check("overflow/count", 64'(count), 64'(DEPTH));
    cycle(0, 1, 32'h1, 32'h2, 0, 32'h3F80_0000, 1, 0, "full_pushpop");
    check("full_pushpop/drop", 64'(drop_cnt), 64'd3);
    drain("fill_drain");
    cycle(1, 0, 0, 0, 0, 0, 0, 0, "cls_reset");
    for (int i = 0; i < 6; i++) begin
      cycle(0, 1, 32'h1234_0000 + i, 32'h5678_0000 + i, 1, cv[i].r, 0, 0, "cls_push");
      check($sformatf("cls_vec%0d", i), 64'(out_class),
            `ifdef FP_MON_CLASS_EN 64'(cv[i].cls) `else 64'd0 `endif);
      cycle(0, 0, 0, 0, 0, 0, 1, 0, "cls_pop");
    end
    check("cls/nan_cnt", 64'(nan_cnt), `ifdef FP_MON_CLASS_EN 64'd1 `else 64'd0 `endif);
    push_n(4, 48, 0, "wrap_fill");
    for (int i = 0; i < 5; i++) push_n(1, 64 + i, 1, "wrap");
    check("wrap/count", 64'(count), 64'd4);
    drain("wrap_drain");
    push_n(5, 80, 0, "flush_fill");
    cycle(0, 1, 32'hA, 32'hB, 0, 32'h7FC0_0001, 1, 1, "flush");
    check("flush/count", 64'(count), 64'd0);
    check("flush/out_valid", 64'(out_valid), 64'd0);
    cycle(0, 0, 0, 0, 0, 0, 1, 0, "post_flush");
    push_n(3, 96, 0, "rst_fill");
    cycle(1, 1, 32'hC, 32'hD, 0, 32'h4040_0000, 0, 0, "mid_reset");
    check("mid_reset/in_ready", 64'(in_ready), 64'd1);
    push_n(1, 112, 0, "after_reset");
    drain("final_drain");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_result_monitor.md
FP_RESULT_MONITOR -- requirements
Module: fp_result_monitor

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; IEEE-754 single layout: sign[31], exponent[30:23], mantissa[22:0].
REQ-002 Parameter DEPTH, default 8, capture FIFO entries; power of two, minimum 2.
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  operand/result sample present this cycle.
REQ-007 in_a, in_b  input  WIDTH each  operands applied to the add/sub unit.
REQ-008 in_op  input  1  operation_select applied (0 add, 1 sub).
REQ-009 in_result  input  WIDTH  add/sub unit result for in_a/in_b/in_op.
REQ-010 in_ready  output  1  high when a sample can be captured (not full).
REQ-011 flush  input  1  discard all stored entries.
REQ-012 out_valid  output  1  FIFO head entry present.
REQ-013 out_ready  input  1  reader consumes head entry.
REQ-014 out_a, out_b, out_result  output  WIDTH each; out_op  output  1  head entry fields.
REQ-015 out_class  output  3  head result class: 0 zero, 1 subnormal, 2 normal, 3 infinity, 4 NaN.
REQ-016 count  output  $clog2(DEPTH)+1  stored entries.
REQ-017 full, empty  output  1 each  FIFO status.
REQ-018 drop_cnt, nan_cnt  output  16 each  dropped samples / captured NaN results.

Function
REQ-019 Push when in_valid && in_ready; entry = {in_a, in_b, in_op, in_result, class}.
REQ-020 in_ready = !full, combinational from registered state; push while full is never accepted, even with a simultaneous pop.
REQ-021 Pop when out_valid && out_ready; read pointer advances at that clock edge.
REQ-022 Latency: sample pushed into empty FIFO at edge N gives out_valid=1 with its fields after edge N.
REQ-023 out_* fields hold stable while out_valid && !out_ready.
REQ-024 Simultaneous push and pop when neither full nor empty: count unchanged, both pointers advance.
REQ-025 Pointers wrap from DEPTH-1 to 0; full = (count==DEPTH), empty = (count==0).
REQ-026 Classification: exp==0 && man==0 zero; exp==0 && man!=0 subnormal; exp==0xFF && man==0 infinity; exp==0xFF && man!=0 NaN; otherwise normal. Sign ignored.
REQ-027 drop_cnt increments when in_valid && !in_ready; saturates at 0xFFFF.
REQ-028 nan_cnt increments on each accepted push with class 4; saturates at 0xFFFF.
REQ-029 Control FSM states: IDLE (empty), ACTIVE (1..DEPTH-1 entries), FULL (DEPTH entries); transitions follow count after each edge; flush forces IDLE.
REQ-030 flush has priority over push and pop in the same cycle: pointers and count go to 0; sample presented that cycle is discarded, not counted in drop_cnt; drop_cnt and nan_cnt retained.

Reset
REQ-031 rst at a clock edge clears pointers, count, drop_cnt, nan_cnt; FSM to IDLE; rst has priority over flush, push and pop.
REQ-032 After reset: out_valid=0, empty=1, full=0, in_ready=1, count=0, drop_cnt=0, nan_cnt=0; out_a/out_b/out_result/out_op/out_class=0.
REQ-033 Reset mid-operation discards all stored entries; no stale entry reappears after reset.
REQ-034 FIFO storage need not be reset; out_* fields read 0 whenever out_valid=0.

Configuration
REQ-035 Macro FP_MON_CLASS_EN: defined -> classifier, out_class and nan_cnt per REQ-026/028.
REQ-036 FP_MON_CLASS_EN undefined -> no classifier logic or class storage; out_class constant 0, nan_cnt constant 0; all else unchanged.

Verification
REQ-037 Reset, then push a=0x3F800000 b=0x40000000 op=0 result=0x40400000 -> next cycle out_valid=1, out_result=0x40400000, out_class=2, count=1.
REQ-038 Push DEPTH+2 samples with out_ready=0 -> full=1 after 8 pushes, in_ready=0, drop_cnt=2, count=8; then drain -> entries out in push order, empty=1.
REQ-039 Results 0x00000000, 0x00000001, 0x7F800000, 0x7FC00000 -> out_class 0,1,3,4; nan_cnt=1 (with FP_MON_CLASS_EN); out_class=0, nan_cnt=0 without.
REQ-040 Count 4, assert push and pop together for 5 cycles -> count stays 4, pointers wrap, data order preserved.
REQ-041 Count 5, assert flush with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, drop_cnt unchanged.
REQ-042 Count 3, assert rst with in_valid=1 -> next cycle count=0, out_valid=0, drop_cnt=0, in_ready=1.
